// File: rtl/vga_fb_pkg.sv
// Shared defaults and the port-owner encoding for the frame-buffer arbiter.
// Optional build macro used by the arbiter: FB_DOUBLE_BUF_EN.
package vga_fb_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_ADDR_W   = 19;
  localparam int DEF_DATA_W   = 12;
  localparam int FB_WORDS     = DEF_H_ACTIVE * DEF_V_ACTIVE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISP_RD = 2'd1,
    WR      = 2'd2
  } owner_t;

  // The display always wins; the writer only gets cycles the display leaves free.
  function automatic owner_t port_owner(logic disp_valid, logic wr_req);
    if (disp_valid)  return DISP_RD;
    else if (wr_req) return WR;
    else             return IDLE;
  endfunction

endpackage

// File: rtl/fb_bank_swap.sv
// Display-bank register for double buffering: a writer frame-done pulse arms a
// swap, and the next vsync assertion flips the displayed bank.
module fb_bank_swap
  import vga_fb_pkg::*;
#(
  parameter logic VSYNC_ACT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic wr_frame_done,
  output logic disp_bank
);

  logic vsync_prev_reg;
  logic pending_reg;
  logic vs_edge;

  // Prev starts at the active level so a vsync already active out of reset is not an edge.
  assign vs_edge = (vsync == VSYNC_ACT) && (vsync_prev_reg != VSYNC_ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_reg <= VSYNC_ACT;
      pending_reg    <= 1'b0;
      disp_bank      <= 1'b0;
    end else begin
      vsync_prev_reg <= vsync;
      if (vs_edge && pending_reg) begin
        disp_bank   <= ~disp_bank;
        pending_reg <= wr_frame_done;
      end else if (wr_frame_done) begin
        pending_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads with fixed latency 3, writer
// admitted only in display-free cycles. Define FB_DOUBLE_BUF_EN for two banks.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   ADDR_W    = DEF_ADDR_W,
  parameter int   DATA_W    = DEF_DATA_W,
  parameter logic VSYNC_ACT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_valid,
  input  logic [11:0]       disp_x,
  input  logic [10:0]       disp_y,
  input  logic              vsync,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_data_vld,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              mem_en,
  output logic              mem_we,
`ifdef FB_DOUBLE_BUF_EN
  output logic [ADDR_W:0]   mem_addr,
`else
  output logic [ADDR_W-1:0] mem_addr,
`endif
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_DOUBLE_BUF_EN
  ,
  input  logic              wr_frame_done,
  output logic              disp_bank
`endif
);

  localparam int FB_SIZE = H_ACTIVE * V_ACTIVE;
`ifdef FB_DOUBLE_BUF_EN
  localparam int MA_W = ADDR_W + 1;
`else
  localparam int MA_W = ADDR_W;
`endif

  owner_t            owner;
  logic              rd_oob;
  logic              wr_oob;
  logic [ADDR_W-1:0] rd_addr;
  logic [MA_W-1:0]   rd_maddr;
  logic [MA_W-1:0]   wr_maddr;
  logic              rd_vld1_reg, rd_oob1_reg;
  logic              rd_vld2_reg, rd_oob2_reg;

  assign owner  = port_owner(disp_valid, wr_req);
  assign wr_ack = rst_n & wr_req & ~disp_valid;

  assign rd_oob  = (int'(disp_x) >= H_ACTIVE) || (int'(disp_y) >= V_ACTIVE);
  assign wr_oob  = 64'(wr_addr) >= 64'(FB_SIZE);
  // Modular arithmetic in ADDR_W bits gives the same result as truncating the full product.
  assign rd_addr = ADDR_W'(disp_y) * ADDR_W'(H_ACTIVE) + ADDR_W'(disp_x);

`ifdef FB_DOUBLE_BUF_EN
  fb_bank_swap #(
    .VSYNC_ACT     (VSYNC_ACT)
  ) u_bank_swap (
    .clk           (clk),
    .rst_n         (rst_n),
    .vsync         (vsync),
    .wr_frame_done (wr_frame_done),
    .disp_bank     (disp_bank)
  );

  // Display reads the shown bank while the writer fills the other one.
  assign rd_maddr = {disp_bank, rd_addr};
  assign wr_maddr = {~disp_bank, wr_addr};
`else
  logic unused_vsync;
  assign unused_vsync = vsync ^ VSYNC_ACT;
  assign rd_maddr = rd_addr;
  assign wr_maddr = wr_addr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      wr_err        <= 1'b0;
      rd_vld1_reg   <= 1'b0;
      rd_oob1_reg   <= 1'b0;
      rd_vld2_reg   <= 1'b0;
      rd_oob2_reg   <= 1'b0;
      disp_data     <= '0;
      disp_data_vld <= 1'b0;
    end else begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      rd_vld1_reg <= (owner == DISP_RD);
      rd_oob1_reg <= rd_oob;
      rd_vld2_reg <= rd_vld1_reg;
      rd_oob2_reg <= rd_oob1_reg;

      case (owner)
        DISP_RD: begin
          if (!rd_oob) begin
            mem_en   <= 1'b1;
            mem_addr <= rd_maddr;
          end
        end
        WR: begin
          // Out-of-range writes are acked but never reach the RAM.
          if (wr_oob) begin
            wr_err <= 1'b1;
          end else begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_maddr;
            mem_wdata <= wr_data;
          end
        end
        default: ;
      endcase

      disp_data_vld <= rd_vld2_reg;
      if (rd_vld2_reg) disp_data <= rd_oob2_reg ? '0 : mem_rdata;
    end
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port frame-buffer arbiter between the VGA scan-out path and the image-processing writer. It takes the pixel coordinates and `valid` from `vga_controller`, issues one synchronous RAM read per visible pixel, and returns the pixel with a fixed latency. Writer requests are admitted only in cycles the display does not need the port, which in practice means blanking. It sits between `vga_controller`, the processing pipeline and the frame-buffer RAM.

## Interface

**Parameters**
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `ADDR_W`, 19: frame-buffer word address width. Must satisfy 2^ADDR_W ≥ H_ACTIVE*V_ACTIVE.
- `DATA_W`, 12: pixel width (RGB444).
- `VSYNC_ACT`, 0: active level of `vsync`.

**Ports**
- `clk` in 1: pixel clock, 25 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `disp_valid` in 1: `valid` from `vga_controller`.
- `disp_x` in 12: pixel column.
- `disp_y` in 11: pixel line.
- `vsync` in 1: from `vga_controller`.
- `disp_data` out DATA_W: pixel to the DAC path.
- `disp_data_vld` out 1: qualifies `disp_data`.
- `wr_req` in 1: writer valid.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in DATA_W: write data.
- `wr_ack` out 1: writer ready. A transfer happens in any cycle where `wr_req` and `wr_ack` are both 1.
- `wr_err` out 1: sticky flag, set by an out-of-range write.
- `mem_en` out 1: RAM enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out ADDR_W, or ADDR_W+1 with FB_DOUBLE_BUF_EN: RAM address.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data, valid 1 cycle after `mem_en`.
- `wr_frame_done` in 1: FB_DOUBLE_BUF_EN only. Pulse marking writer frame complete.
- `disp_bank` out 1: FB_DOUBLE_BUF_EN only. Bank currently displayed.

## Operation

- **Reset:** every output is 0, `wr_err` clears, the bank is 0 and no swap is pending. Any command already issued is discarded. An unacked write is not performed, and the writer must re-present it.
- **Port ownership:** decided per cycle. Display has absolute priority.
  - `disp_valid`=1: display read.
  - `disp_valid`=0 and `wr_req`=1: write.
  - Otherwise: idle.
- **Display read:**
  - Address is `disp_y*H_ACTIVE + disp_x`, truncated to ADDR_W. Multiplication is by a constant.
  - If `disp_x` ≥ H_ACTIVE or `disp_y` ≥ V_ACTIVE while `disp_valid`=1: no RAM access, and `disp_data`=0 with `disp_data_vld`=1 at the normal latency.
- **Write acceptance:** `wr_ack` is combinational: `rst_n & wr_req & ~disp_valid`.
  - A `wr_req` held high across consecutive free cycles performs consecutive writes, one per cycle.
  - While `disp_valid`=1 the writer stalls with `wr_ack`=0 and must keep addr and data stable.
- **Range check:** an accepted write with `wr_addr` ≥ H_ACTIVE*V_ACTIVE is still acked but dropped (`mem_we`=0), and it sets `wr_err`.
- **Simultaneous events:** `disp_valid` and `wr_req` rising in the same cycle give the cycle to the display. The write is taken in the first cycle with `disp_valid`=0.

## Timing

- All RAM outputs are registered.
- **Display path:** `disp_valid` sampled at cycle N.
  - N+1: `mem_en`=1, `mem_we`=0, `mem_addr` driven.
  - N+2: `mem_rdata` returns.
  - N+3: `disp_data` and `disp_data_vld` registered.
  - Fixed latency is 3. Downstream delays `hsync`/`vsync` by 3 to align.
- **Write path:** handshake at cycle N gives `mem_en`=`mem_we`=1 with address and data at N+1. `wr_err` rises at N+1.
- `disp_data_vld` is 0 in all other cycles. `disp_data` holds its last value.

## Configuration

- **`FB_DOUBLE_BUF_EN` undefined:** single buffer. The `wr_frame_done` and `disp_bank` ports are absent. `mem_addr` is ADDR_W bits.
- **`FB_DOUBLE_BUF_EN` defined:** two banks, and `mem_addr` gains an MSB bank bit.
  - Reads use `disp_bank`. Writes use `~disp_bank`.
  - A `wr_frame_done` pulse sets swap-pending. A pulse while swap is already pending is ignored.
  - On the first cycle `vsync` equals VSYNC_ACT after being inactive, with swap pending: `disp_bank` toggles on the next edge and pending clears.
  - A `wr_frame_done` in the same cycle as the vsync edge that consumes pending re-arms pending.
  - Without pending, the vsync edge does nothing.

## Structure

- **Package `vga_fb_pkg`:** default H_ACTIVE, V_ACTIVE, ADDR_W, DATA_W; `FB_WORDS` = H_ACTIVE*V_ACTIVE; a typedef for the port-owner encoding (IDLE, DISP_RD, WR).
- **Sub-module `fb_bank_swap`:** vsync edge detect, swap-pending flag and bank register. Instantiated only under FB_DOUBLE_BUF_EN.

## Test plan

1. **Display read:** `disp_valid`=1, x=5, y=2 at cycle N → `mem_addr`=1285, `mem_en`=1 at N+1. RAM returns 0xABC → `disp_data`=0xABC with `disp_data_vld`=1 at N+3.
2. **Write stalled by display:** `wr_req` with addr 100, data 0x123 while `disp_valid`=1 for 6 cycles → `wr_ack`=0 throughout. In the first cycle with `disp_valid`=0, `wr_ack`=1, and the next cycle shows `mem_we`=1, `mem_addr`=100, `mem_wdata`=0x123.
3. **Burst write in blanking:** `wr_req` held 4 cycles with addresses 10..13 → 4 acks, then 4 consecutive `mem_we` cycles with matching addresses.
4. **Out-of-range write:** `wr_addr`=307200 → ack, no `mem_we`, `wr_err`=1 and sticky until reset. Separately, `disp_x`=640 → `disp_data`=0 with vld, no `mem_en`.
5. **Bank swap (FB_DOUBLE_BUF_EN):** `wr_frame_done` pulse, then vsync edge → `disp_bank` 0→1. Reads carry MSB 1 and writes carry MSB 0. A second vsync edge with no pulse → no toggle.
6. **Reset mid-operation:** `rst_n` low during an active read burst → all outputs 0 immediately. After release, the first `disp_valid` yields a read at latency 3.
